// File: rtl/fifo_sync_level.sv
// rtl/fifo_sync_level.sv - FWFT sync FIFO with exact fill count, runtime level flags and flush
module ram_dp #(
    parameter int    DataWidth  = 16,
    parameter int    AddrWidth  = 10,
    parameter string VendorImpl = ""
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [DataWidth-1:0] rd_data_o
);

    // Read-first registered read port; the FIFO never reads a slot written on the same edge.
    generate
        if (VendorImpl == "") begin : g_generic
            logic [DataWidth-1:0] mem_q [2**AddrWidth];

            always_ff @(posedge clk) begin
                if (wr_en_i) begin
                    mem_q[wr_addr_i] <= wr_data_i;
                end
                rd_data_o <= mem_q[rd_addr_i];
            end
        end else begin : g_vendor
            (* ram_style = "block" *) logic [DataWidth-1:0] mem_q [2**AddrWidth];

            always_ff @(posedge clk) begin
                if (wr_en_i) begin
                    mem_q[wr_addr_i] <= wr_data_i;
                end
                rd_data_o <= mem_q[rd_addr_i];
            end
        end
    endgenerate

endmodule

module fifo_sync_level #(
    parameter int    DataWidth  = 16,
    parameter int    AddrWidth  = 10,
    parameter int    DataDepth  = 1024,
    parameter string VendorImpl = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 write_en,
    input  logic [DataWidth-1:0] write_data,
    input  logic                 read_en,
    output logic [DataWidth-1:0] read_data,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic [AddrWidth:0]   fill_count,
    input  logic [AddrWidth:0]   af_level,
    input  logic [AddrWidth:0]   ae_level,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [AddrWidth-1:0] LastPtr = AddrWidth'(DataDepth - 1);
    localparam logic [AddrWidth:0]   Depth   = (AddrWidth + 1)'(DataDepth);

    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrWidth:0]   count_q, count_d;
    logic                 full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic                 empty_d;
    logic                 clear;
    logic                 wr_acc, rd_acc;

    function automatic logic [AddrWidth-1:0] ptr_inc(input logic [AddrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + AddrWidth'(1);
    endfunction

    assign clear  = reset | flush;
    assign wr_acc = write_en & (~full_q | (read_en & ~empty_q));
    assign rd_acc = read_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + (AddrWidth + 1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - (AddrWidth + 1)'(1);
            end
        end
    end

    // The head is valid only if it was written before this edge; same-edge writes show up one edge later.
    assign empty_d = clear | (count_q <= {{AddrWidth{1'b0}}, rd_acc});

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == Depth);
            empty_q  <= empty_d;
            af_q     <= (count_d >= af_level);
            ae_q     <= (count_d <= ae_level);
            ovf_q    <= write_en & ~wr_acc;
            unf_q    <= read_en & empty_q;
        end
    end

    // Reading at the next head address every cycle gives zero-bubble prefetch on pop.
    ram_dp #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth),
        .VendorImpl(VendorImpl)
    ) u_ram (
        .clk      (clk),
        .wr_en_i  (wr_acc & ~clear),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(write_data),
        .rd_addr_i(rd_ptr_d),
        .rd_data_o(read_data)
    );

    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign fill_count   = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
